// File: rtl/rmc_req_packer.sv
// rtl/rmc_req_packer.sv - serialises one command plus its write data into cpu_rmc request words
// Optional build macro RMC_PACK_CHECK_EN adds err_cnt and drops commands with an illegal word count.
module rmc_req_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 8,
    parameter int NW_WIDTH   = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_type,
    input  logic [DATA_WIDTH-1:0] cmd_addr,
    input  logic [NW_WIDTH-1:0]   cmd_num_words,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  fifo_enq,
    input  logic                  fifo_wrfull,
`ifdef RMC_PACK_CHECK_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR0 = 2'd1,
        HDR1 = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t                state_q;
    logic [NW_WIDTH-1:0]   words_left_q;
    logic                  type_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [NW_WIDTH-1:0]   nw_q;

`ifdef RMC_PACK_CHECK_EN
    localparam logic [NW_WIDTH-1:0] MAX_NW = NW_WIDTH'(MAX_WORDS);

    logic [7:0] err_cnt_q;
    logic       cmd_bad;

    assign cmd_bad = (cmd_num_words == '0) || (cmd_num_words > MAX_NW);
    assign err_cnt = err_cnt_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            type_q       <= 1'b0;
            addr_q       <= '0;
            nw_q         <= '0;
`ifdef RMC_PACK_CHECK_EN
            err_cnt_q    <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        type_q <= cmd_type;
                        addr_q <= cmd_addr;
                        nw_q   <= cmd_num_words;
`ifdef RMC_PACK_CHECK_EN
                        // Illegal counts complete the handshake but never reach the FIFO.
                        if (cmd_bad) begin
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        end else begin
                            state_q <= HDR0;
                        end
`else
                        state_q <= HDR0;
`endif
                    end
                end
                HDR0: begin
                    if (fifo_enq) state_q <= HDR1;
                end
                HDR1: begin
                    if (fifo_enq) begin
                        if (type_q && (nw_q != '0)) begin
                            state_q      <= DATA;
                            words_left_q <= nw_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (fifo_enq) begin
                        words_left_q <= words_left_q - NW_WIDTH'(1);
                        if (words_left_q == NW_WIDTH'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshakes and the FIFO word are combinational so a full FIFO stalls without a lost cycle.
    always_comb begin
        cmd_ready    = 1'b0;
        wdata_ready  = 1'b0;
        fifo_enq     = 1'b0;
        fifo_data_in = '0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            HDR0: begin
                fifo_data_in = {{(DATA_WIDTH-NW_WIDTH-1){1'b0}}, nw_q, type_q};
                fifo_enq     = !fifo_wrfull;
            end
            HDR1: begin
                fifo_data_in = addr_q;
                fifo_enq     = !fifo_wrfull;
            end
            DATA: begin
                fifo_data_in = wdata;
                fifo_enq     = wdata_valid && !fifo_wrfull;
                wdata_ready  = wdata_valid && !fifo_wrfull;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rmc_req_packer.sv
// tb/tb_rmc_req_packer.sv - directed self-checking bench for rmc_req_packer
module tb_rmc_req_packer;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_type;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_num_words;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic [31:0] fifo_data_in;
    logic        fifo_enq;
    logic        fifo_wrfull;
    logic        busy;
`ifdef RMC_PACK_CHECK_EN
    logic [7:0]  err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    rmc_req_packer dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_addr     (cmd_addr),
        .cmd_num_words(cmd_num_words),
        .wdata_valid  (wdata_valid),
        .wdata_ready  (wdata_ready),
        .wdata        (wdata),
        .fifo_data_in (fifo_data_in),
        .fifo_enq     (fifo_enq),
        .fifo_wrfull  (fifo_wrfull),
`ifdef RMC_PACK_CHECK_EN
        .err_cnt      (err_cnt),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checking.
    task automatic cyc(input logic cv, input logic ct, input logic [31:0] ca, input logic [3:0] cn,
                       input logic wv, input logic [31:0] wd, input logic full);
        @(negedge clk);
        cmd_valid     = cv;
        cmd_type      = ct;
        cmd_addr      = ca;
        cmd_num_words = cn;
        wdata_valid   = wv;
        wdata         = wd;
        fifo_wrfull   = full;
        #1;
    endtask

    task automatic out(input string tag, input logic cr, input logic wr, input logic enq,
                       input logic [31:0] d, input logic b);
        chk({tag, ".cmd_ready"}, {31'd0, cmd_ready}, {31'd0, cr});
        chk({tag, ".wdata_ready"}, {31'd0, wdata_ready}, {31'd0, wr});
        chk({tag, ".fifo_enq"}, {31'd0, fifo_enq}, {31'd0, enq});
        if (enq || !fifo_enq) chk({tag, ".fifo_data_in"}, fifo_data_in, d);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    initial begin
        rstn = 1'b0;
        cmd_valid = 0; cmd_type = 0; cmd_addr = 0; cmd_num_words = 0;
        wdata_valid = 0; wdata = 0; fifo_wrfull = 0;
        repeat (2) @(negedge clk);
        #1;
        out("reset", 1, 0, 0, 32'h0, 0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: READ 0x10 count 3, stray write data must be ignored
        cyc(1, 0, 32'h10, 4'd3, 1, 32'hDEAD0001, 0); out("t1.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hDEAD0002, 0); out("t1.hdr0", 0, 0, 1, 32'h6, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hDEAD0003, 0); out("t1.hdr1", 0, 0, 1, 32'h10, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hDEAD0004, 0); out("t1.idle", 1, 0, 0, 32'h0, 0);

        // 2: WRITE 0x20 count 2, data offered early
        cyc(1, 1, 32'h20, 4'd2, 1, 32'hAAAA5555, 0); out("t2.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hAAAA5555, 0); out("t2.hdr0", 0, 0, 1, 32'h5, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hAAAA5555, 0); out("t2.hdr1", 0, 0, 1, 32'h20, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hAAAA5555, 0); out("t2.d0", 0, 1, 1, 32'hAAAA5555, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h12345678, 0); out("t2.d1", 0, 1, 1, 32'h12345678, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h12345678, 0); out("t2.idle", 1, 0, 0, 32'h0, 0);

        // 3: same packet, FIFO full for 3 cycles in HDR1
        cyc(1, 1, 32'h20, 4'd2, 0, 32'h0, 0); out("t3.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 0, 32'h0, 0); out("t3.hdr0", 0, 0, 1, 32'h5, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'h0, 4'd0, 1, 32'hAAAA5555, 1); out("t3.stall", 0, 0, 0, 32'h20, 1);
        end
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hAAAA5555, 0); out("t3.hdr1", 0, 0, 1, 32'h20, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hAAAA5555, 0); out("t3.d0", 0, 1, 1, 32'hAAAA5555, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h12345678, 1); out("t3.dfull", 0, 0, 0, 32'h12345678, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h12345678, 0); out("t3.d1", 0, 1, 1, 32'h12345678, 1);
        cyc(0, 0, 32'h0, 4'd0, 0, 32'h0, 0); out("t3.idle", 1, 0, 0, 32'h0, 0);

        // 4: WRITE 0x40 count 4, valid toggling
        cyc(1, 1, 32'h40, 4'd4, 0, 32'h0, 0); out("t4.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 0, 32'h0, 0); out("t4.hdr0", 0, 0, 1, 32'h9, 1);
        cyc(0, 0, 32'h0, 4'd0, 0, 32'h0, 0); out("t4.hdr1", 0, 0, 1, 32'h40, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 32'h0, 4'd0, 1, 32'hC0DE0000 + i, 0); out("t4.dv", 0, 1, 1, 32'hC0DE0000 + i, 1);
            if (i < 3) begin
                cyc(0, 0, 32'h0, 4'd0, 0, 32'hBAD00000, 0); out("t4.dn", 0, 0, 0, 32'hBAD00000, 1);
            end
        end
        cyc(0, 0, 32'h0, 4'd0, 1, 32'hBAD00001, 0); out("t4.idle", 1, 0, 0, 32'h0, 0);

        // 5: reset after the first of 4 data words
        cyc(1, 1, 32'h50, 4'd4, 1, 32'h11110000, 0); out("t5.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h11110000, 0); out("t5.hdr0", 0, 0, 1, 32'h9, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h11110000, 0); out("t5.hdr1", 0, 0, 1, 32'h50, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h11110000, 0); out("t5.d0", 0, 1, 1, 32'h11110000, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h11110001, 0);
        rstn = 1'b0;
        #1;
        out("t5.rst", 1, 0, 0, 32'h0, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        out("t5.post", 1, 0, 0, 32'h0, 0);
        cyc(1, 0, 32'h60, 4'd2, 1, 32'h11110002, 0); out("t5.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h11110002, 0); out("t5.hdr0", 0, 0, 1, 32'h4, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h11110002, 0); out("t5.hdr1", 0, 0, 1, 32'h60, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'h0, 4'd0, 1, 32'h11110003, 0); out("t5.quiet", 1, 0, 0, 32'h0, 0);
        end

        // 6: zero-count WRITE sends headers only in the default build; dropped when checking
`ifdef RMC_PACK_CHECK_EN
        chk("t6.err0", {24'd0, err_cnt}, 32'd0);
        cyc(1, 1, 32'h70, 4'd0, 1, 32'h0, 0); out("t6.c0", 1, 0, 0, 32'h0, 0);
        cyc(1, 1, 32'h70, 4'd9, 1, 32'h0, 0); out("t6.c9", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h0, 0); out("t6.drop", 1, 0, 0, 32'h0, 0);
        chk("t6.err2", {24'd0, err_cnt}, 32'd2);
        cyc(1, 0, 32'h70, 4'd1, 0, 32'h0, 0); out("t6.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 0, 32'h0, 0); out("t6.hdr0", 0, 0, 1, 32'h2, 1);
        cyc(0, 0, 32'h0, 4'd0, 0, 32'h0, 0); out("t6.hdr1", 0, 0, 1, 32'h70, 1);
        cyc(0, 0, 32'h0, 4'd0, 0, 32'h0, 0); out("t6.idle", 1, 0, 0, 32'h0, 0);
        chk("t6.err_hold", {24'd0, err_cnt}, 32'd2);
`else
        cyc(1, 1, 32'h70, 4'd0, 1, 32'h0, 0); out("t6.accept", 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h0, 0); out("t6.hdr0", 0, 0, 1, 32'h1, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h0, 0); out("t6.hdr1", 0, 0, 1, 32'h70, 1);
        cyc(0, 0, 32'h0, 4'd0, 1, 32'h0, 0); out("t6.idle", 1, 0, 0, 32'h0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
